// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction-fetch stage: reset level, bus widths,
// the NOP encoding presented while no instruction is valid, and the encoding
// of the fetch FSM states.
// -----------------------------------------------------------------------------
package if_fetch_pkg;

   localparam logic RstEnable   = 1'b1;
   localparam int   InstAddrBus = 32;
   localparam int   InstBus     = 32;

   localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;
   // addi x0, x0, 0
   localparam logic [InstBus-1:0] NopInst  = 32'h0000_0013;

   typedef enum logic {
      IF_FETCH   = 1'b0,
      IF_PRESENT = 1'b1
   } if_state_e;

endpackage

// File: rtl/if_icache.sv
// -----------------------------------------------------------------------------
// if_icache
// Direct-mapped instruction cache for the fetch stage. Only compiled when the
// IF_ICACHE_EN macro is defined.
//
// Ports:
//   clk_in, rst_in  clock, asynchronous active-high reset (clears valid bits)
//   lookup_pc       PC being fetched; hit/hit_word are combinational on it
//   hit             entry at lookup_pc is valid and its tag matches
//   hit_word        cached instruction word for lookup_pc
//   fill_en         write fill_word into the entry for fill_pc this cycle
//   fill_pc         PC of the word being filled
//   fill_word       assembled instruction word
//
// Index = pc[log2(LINES)+1:2], tag = pc[31:log2(LINES)+2]. Tag and data arrays
// carry no reset; only the valid bits are cleared.
// -----------------------------------------------------------------------------
`ifdef IF_ICACHE_EN
module if_icache
   import if_fetch_pkg::*;
#(
   parameter int LINES = 64
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [InstAddrBus-1:0] lookup_pc,
   output logic                   hit,
   output logic [InstBus-1:0]     hit_word,
   input  logic                   fill_en,
   input  logic [InstAddrBus-1:0] fill_pc,
   input  logic [InstBus-1:0]     fill_word
);

   localparam int IdxW = $clog2(LINES);
   localparam int TagW = InstAddrBus - IdxW - 2;

   logic [LINES-1:0]   valid_q;
   logic [TagW-1:0]    tag_q  [LINES];
   logic [InstBus-1:0] data_q [LINES];

   logic [IdxW-1:0] lookup_idx;
   logic [IdxW-1:0] fill_idx;
   logic [TagW-1:0] lookup_tag;
   logic [TagW-1:0] fill_tag;

   assign lookup_idx = lookup_pc[IdxW+1:2];
   assign lookup_tag = lookup_pc[InstAddrBus-1:IdxW+2];
   assign fill_idx   = fill_pc[IdxW+1:2];
   assign fill_tag   = fill_pc[InstAddrBus-1:IdxW+2];

   assign hit      = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
   assign hit_word = data_q[lookup_idx];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in == RstEnable) begin
         valid_q <= '0;
      end else if (fill_en) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (fill_en) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= fill_word;
      end
   end

   // Word-aligned PCs only: byte-offset bits carry no information here.
   logic unused_offset;
   assign unused_offset = ^{lookup_pc[1:0], fill_pc[1:0]};

endmodule
`endif

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage of the 5-stage RV32I pipeline. Holds the PC, fetches
// each instruction as four byte reads through the memory-arbiter port,
// assembles them little-endian and presents {pc_out, inst_out,
// inst_valid_out} to the IF/ID register. Honours stall_in from the stall
// controller and redirects (jump_in) from EX.
//
// Optional build macro: IF_ICACHE_EN adds a direct-mapped I-cache (if_icache)
// of ICACHE_LINES entries; a hit presents the instruction one cycle after
// entering FETCH with no memory traffic.
//
// Ports:
//   clk_in, rst_in     clock, asynchronous active-high reset
//   stall_in           IF/ID cannot accept; hold the presented instruction
//   jump_in            redirect request from EX (beats stall_in)
//   jump_target_in     redirect PC, bits [1:0] ignored
//   mem_req_out        byte read request to the arbiter
//   mem_addr_out       byte address of the request
//   mem_grant_in       arbiter accepts the request this cycle
//   mem_valid_in       read data valid, exactly 1 cycle after a grant
//   mem_data_in        read byte
//   pc_out, inst_out   presented instruction and its PC
//   inst_valid_out     pc_out/inst_out hold a valid instruction
//   dbg_state          current FSM state
//
// Handshakes: a byte request transfers in any cycle where mem_req_out and
// mem_grant_in are both high; mem_addr_out is stable while mem_req_out waits
// for a grant, and the byte returns on mem_valid_in in the very next cycle.
// Toward IF/ID, inst_valid_out is "valid" and !stall_in is "ready": the
// instruction transfers in a cycle where both are high, and pc_out/inst_out
// stay frozen while valid is high and ready is low.
// -----------------------------------------------------------------------------
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] RESET_PC     = 32'h0000_0000,
   parameter int                     ICACHE_LINES = 64
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   stall_in,
   input  logic                   jump_in,
   input  logic [InstAddrBus-1:0] jump_target_in,
   output logic                   mem_req_out,
   output logic [InstAddrBus-1:0] mem_addr_out,
   input  logic                   mem_grant_in,
   input  logic                   mem_valid_in,
   input  logic [7:0]             mem_data_in,
   output logic [InstAddrBus-1:0] pc_out,
   output logic [InstBus-1:0]     inst_out,
   output logic                   inst_valid_out,
   output if_state_e              dbg_state
);

   if_state_e              state;
   if_state_e              state_nxt;
   logic [InstAddrBus-1:0] pc;
   logic [2:0]             issue_cnt;   // byte requests granted, 0..4
   logic [2:0]             recv_cnt;    // bytes received, 0..4
   logic                   in_flight;   // a grant last cycle: its byte arrives now
   logic                   discard;     // that byte belongs to a redirected fetch
   logic [23:0]            inst_buf;    // bytes 0..2; byte 3 comes straight off the bus

   logic                   grant_take;
   logic                   byte_take;
   logic                   last_byte;
   logic                   hit_now;
   logic                   fetch_done;
   logic [InstBus-1:0]     fetch_word;
   logic [InstBus-1:0]     byte_word;
   logic                   cache_hit;
   logic [InstBus-1:0]     cache_word;

   assign dbg_state = state;

   assign grant_take = mem_req_out && mem_grant_in;
   assign byte_take  = (state == IF_FETCH) && mem_valid_in && in_flight && !discard;
   assign last_byte  = byte_take && (recv_cnt == 3'd3);
   // A cache lookup only counts before the first byte request is granted.
   assign hit_now    = (state == IF_FETCH) && (issue_cnt == 3'd0) && cache_hit;
   assign fetch_done = !jump_in && (last_byte || hit_now);
   assign byte_word  = {mem_data_in, inst_buf};
   assign fetch_word = hit_now ? cache_word : byte_word;

`ifdef IF_ICACHE_EN
   // A fill is skipped when a redirect lands on the cycle the last byte arrives.
   if_icache #(
      .LINES(ICACHE_LINES)
   ) u_icache (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .lookup_pc (pc),
      .hit       (cache_hit),
      .hit_word  (cache_word),
      .fill_en   (last_byte && !jump_in),
      .fill_pc   (pc),
      .fill_word (byte_word)
   );

   logic unused_cfg;
   assign unused_cfg = ^jump_target_in[1:0];
`else
   assign cache_hit  = 1'b0;
   assign cache_word = ZeroWord;

   logic unused_cfg;
   assign unused_cfg = ^{jump_target_in[1:0], 32'(ICACHE_LINES)};
`endif

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in == RstEnable) begin
         state <= IF_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      case (state)
         IF_FETCH: begin
            if (fetch_done) state_nxt = IF_PRESENT;
         end
         IF_PRESENT: begin
            if (jump_in || !stall_in) state_nxt = IF_FETCH;
         end
         default: state_nxt = IF_FETCH;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // The request is gated by rst_in so the port reads idle for the whole
   // reset pulse, not just after the next clock edge.
   always_comb begin
      mem_req_out  = 1'b0;
      mem_addr_out = ZeroWord;
      if ((rst_in != RstEnable) && (state == IF_FETCH) &&
          (issue_cnt < 3'd4) && !hit_now) begin
         mem_req_out  = 1'b1;
         mem_addr_out = pc + {29'b0, issue_cnt};
      end
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in == RstEnable) begin
         pc             <= RESET_PC;
         issue_cnt      <= 3'd0;
         recv_cnt       <= 3'd0;
         in_flight      <= 1'b0;
         discard        <= 1'b0;
         inst_buf       <= 24'h0;
         pc_out         <= ZeroWord;
         inst_out       <= NopInst;
         inst_valid_out <= 1'b0;
      end else begin
         // A byte granted in a redirect cycle still comes back next cycle;
         // it is marked to be dropped instead of counted.
         in_flight <= grant_take && !jump_in;
         discard   <= grant_take && jump_in;

         if (jump_in) begin
            pc             <= {jump_target_in[InstAddrBus-1:2], 2'b00};
            issue_cnt      <= 3'd0;
            recv_cnt       <= 3'd0;
            inst_valid_out <= 1'b0;
         end else if (state == IF_PRESENT) begin
            if (!stall_in) begin
               pc             <= pc + 32'd4;
               issue_cnt      <= 3'd0;
               recv_cnt       <= 3'd0;
               inst_valid_out <= 1'b0;
            end
         end else begin
            if (grant_take) issue_cnt <= issue_cnt + 3'd1;
            if (byte_take) begin
               recv_cnt <= recv_cnt + 3'd1;
               case (recv_cnt[1:0])
                  2'd0:    inst_buf[7:0]   <= mem_data_in;
                  2'd1:    inst_buf[15:8]  <= mem_data_in;
                  2'd2:    inst_buf[23:16] <= mem_data_in;
                  default: ;
               endcase
            end
            if (fetch_done) begin
               pc_out         <= pc;
               inst_out       <= fetch_word;
               inst_valid_out <= 1'b1;
            end
         end
      end
   end

endmodule
